seq_detector_param: RTL
=======================

Name: seq_detector_param

Overview:
- Parametrised serial pattern detector; successor to the fixed 8-bit BCD "60" FSM detector.
- Pattern and care-mask are loaded at runtime; detection can be overlapping or non-overlapping.
- Accepts one bit per cycle when a valid qualifier is high; emits a single-cycle match pulse and keeps a saturating match count.
- Sits between a serial bit source (deserialiser/testbench stream) and control logic that consumes match events.

Parameters:
- PAT_W, 8, pattern length in bits (2..32). Pattern MSB is the first bit received.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- s_in  input  1  serial data bit
- s_valid  input  1  s_in is sampled on a rising edge only when high
- load  input  1  latch pattern/mask, flush history
- pattern  input  PAT_W  target sequence, sampled on load
- mask  input  PAT_W  1 = compare bit, 0 = don't care, sampled on load
- overlap_en  input  1  1 = overlapping detection, 0 = restart after a match
- d_out  output  1  registered match pulse
- match_cnt  output  CNT_W  saturating count of matches
- armed  output  1  history holds PAT_W valid bits since the last flush

Behaviour:
- Reset (rst_n low, asynchronous) clears the following: pat_r, mask_r, shreg, fill, match_cnt, d_out, armed; state goes to IDLE.
- Registers:
  - pat_r and mask_r hold the loaded pattern and mask.
  - shreg[PAT_W-1:0] holds history. On an accepted bit, shreg <= {shreg[PAT_W-2:0], s_in}.
  - fill counter is $clog2(PAT_W+1) bits wide and saturates at PAT_W.
- States:
  - IDLE: no pattern loaded. Bits are ignored; d_out = 0.
  - FILL: fill < PAT_W. Each accepted bit shifts in and increments fill. When fill reaches PAT_W, go to ARMED.
  - ARMED: each accepted bit shifts in. The match is evaluated on the new shreg value, nxt.
- Match condition (ARMED, or the accepted bit that completes the fill):
  - Condition: ((nxt ^ pat_r) & mask_r) == 0.
  - On a match, d_out = 1 in the cycle after the final bit's edge, for exactly one cycle. Otherwise d_out = 0.
- Overlap handling after a match:
  - overlap_en = 1: stay ARMED. The next accepted bit can match again.
  - overlap_en = 0: fill is cleared to 0, state goes to FILL, and shreg is kept. PAT_W fresh bits are needed before the next match.
- s_valid low: shreg, fill and state hold; d_out = 0 next cycle.
- load:
  - Has priority over s_valid in the same cycle; that cycle's bit is discarded.
  - Captures pattern/mask, clears shreg and fill, and goes to FILL from any state.
  - Does not clear match_cnt.
  - d_out = 0 in the next cycle.
- match_cnt increments by 1 on every match pulse and saturates at 2^CNT_W-1 (no wrap).
- armed = 1 in ARMED, else 0. It is registered and follows the state.
- mask_r all zeros: every accepted bit in ARMED matches.
- overlap_en may change at any time. It is sampled on the cycle of the match.
- rst_n asserted mid-stream: all history and the count are lost immediately; a load is required again.

Optional Feature:
- Macro SEQ_DET_MATCH_CNT_EN.
- Defined: the match counter is implemented as described.
- Undefined: no counter flops; match_cnt is tied to all zeros. d_out and armed are unaffected.

Test Plan:
- Load pattern 0x60, mask 0xFF, overlap_en 1. Stream 0110_0000 MSB first with s_valid high.
  - d_out = 1 for one cycle after the 8th bit; match_cnt = 1.
- Same pattern, then stream 0x12, 0x60, 0x60, 0x00 MSB first.
  - Exactly two d_out pulses, after bits 16 and 24; match_cnt = 2.
- PAT_W=4, load 1010, mask 1111, overlap_en 1, stream 1010101.
  - Pulses after bits 4 and 6.
  - Repeat with overlap_en 0: one pulse, after bit 4 only.
- Load 0x60 with mask 0xF0, stream 0110_1011.
  - Match after bit 8.
  - Stream 1110_0000: no match.
- Toggle s_valid low for 3 cycles in the middle of a 0x60 stream.
  - The match still occurs after the 8th accepted bit; no pulse while s_valid is low.
- Assert rst_n low after 5 bits of 0x60, then release and stream the remaining bits.
  - No match; d_out = 0, match_cnt = 0, armed = 0.
- CNT_W=2: produce 5 matches.
  - match_cnt saturates at 3.
- load asserted together with s_valid on the final bit.
  - No pulse; armed = 0 next cycle.

Source files
------------

// File: rtl/seq_detector_param_if.sv
// rtl/seq_detector_param_if.sv - serial stream and match-event bundle for seq_detector_param
interface seq_detector_param_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
);
    logic             s_in;
    logic             s_valid;
    logic             load;
    logic [PAT_W-1:0] pattern;
    logic [PAT_W-1:0] mask;
    logic             overlap_en;
    logic             d_out;
    logic [CNT_W-1:0] match_cnt;
    logic             armed;

    modport master (
        output s_in, s_valid, load, pattern, mask, overlap_en,
        input  d_out, match_cnt, armed
    );

    modport slave (
        input  s_in, s_valid, load, pattern, mask, overlap_en,
        output d_out, match_cnt, armed
    );
endinterface

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-loadable masked serial pattern detector; match counter enabled by SEQ_DET_MATCH_CNT_EN
module seq_detector_param #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_detector_param_if.slave bus
);
    localparam int              FW        = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]   FILL_LAST = FW'(PAT_W - 1);
    localparam logic [FW-1:0]   FILL_FULL = FW'(PAT_W);

    typedef enum logic [1:0] {IDLE, FILL, ARMED} state_t;

    state_t           state;
    logic [PAT_W-1:0] pat_r;
    logic [PAT_W-1:0] mask_r;
    logic [PAT_W-1:0] shreg;
    logic [PAT_W-1:0] nxt;
    logic [FW-1:0]    fill;
    logic             d_out_r;
    logic             armed_r;
    logic             accept;
    logic             completes;
    logic             hit;

    // Next history word and match decision for the bit on the bus this cycle
    always_comb begin
        nxt       = {shreg[PAT_W-2:0], bus.s_in};
        accept    = bus.s_valid && !bus.load && (state != IDLE);
        completes = (state == ARMED) || ((state == FILL) && (fill == FILL_LAST));
        hit       = accept && completes && (((nxt ^ pat_r) & mask_r) == '0);
    end

    // Detector FSM: load handling, history shift, fill tracking and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pat_r   <= '0;
            mask_r  <= '0;
            shreg   <= '0;
            fill    <= '0;
            d_out_r <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            d_out_r <= 1'b0;
            if (bus.load) begin
                // A load wins over a same-cycle bit, which is dropped
                pat_r   <= bus.pattern;
                mask_r  <= bus.mask;
                shreg   <= '0;
                fill    <= '0;
                state   <= FILL;
                armed_r <= 1'b0;
            end else if (accept) begin
                shreg   <= nxt;
                d_out_r <= hit;
                if (hit && !bus.overlap_en) begin
                    // Non-overlapping: keep the history but demand PAT_W fresh bits
                    fill    <= '0;
                    state   <= FILL;
                    armed_r <= 1'b0;
                end else if (state == FILL) begin
                    if (completes) begin
                        fill    <= FILL_FULL;
                        state   <= ARMED;
                        armed_r <= 1'b1;
                    end else begin
                        fill <= fill + FW'(1);
                    end
                end
            end
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_r;

    // Count match events, holding at full scale instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (hit && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign bus.match_cnt = cnt_r;
`else
    assign bus.match_cnt = '0;
`endif

    assign bus.d_out = d_out_r;
    assign bus.armed = armed_r;

endmodule
